// File: rtl/ahblite_s_port.sv
// Slave-side AHB-Lite interconnect port: arbitrates master ports round-robin into one slave stream.
// Latency: grant one cycle after request; address phase then data phase (two cycles with a zero-wait slave).
// Backpressure: slave hreadyout stretches the data phase and is echoed on s_hready_o; the grant is held meanwhile.
module ahblite_s_port #(
    parameter int AHB_AW  = 32,
    parameter int AHB_DW  = 32,
    parameter int MST_NUM = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MST_NUM-1:0]          m_req_i,
    output logic [MST_NUM-1:0]          m_grant_o,
    input  logic [MST_NUM*AHB_AW-1:0]   m_haddr_i,
    input  logic [MST_NUM-1:0]          m_hwrite_i,
    input  logic [MST_NUM*2-1:0]        m_htrans_i,
    input  logic [MST_NUM*3-1:0]        m_hsize_i,
    input  logic [MST_NUM*3-1:0]        m_hburst_i,
    input  logic [MST_NUM*4-1:0]        m_hprot_i,
    input  logic [MST_NUM-1:0]          m_hmastlock_i,
    input  logic [MST_NUM*AHB_DW-1:0]   m_hwdata_i,
    output logic                        s_hready_o,
    output logic                        s_hresp_o,
    output logic [AHB_DW-1:0]           s_hrdata_o,
    output logic                        hsel_o,
    output logic [AHB_AW-1:0]           haddr_o,
    output logic                        hwrite_o,
    output logic [1:0]                  htrans_o,
    output logic [2:0]                  hsize_o,
    output logic [2:0]                  hburst_o,
    output logic [3:0]                  hprot_o,
    output logic                        hmastlock_o,
    output logic [AHB_DW-1:0]           hwdata_o,
    output logic                        hready_o,
    input  logic                        hreadyout_i,
    input  logic                        hresp_i,
    input  logic [AHB_DW-1:0]           hrdata_i
);
    localparam int IW = $clog2(MST_NUM);
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;
    localparam logic [MST_NUM-1:0] GNT_ONE = MST_NUM'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    typedef struct packed {
        logic [AHB_AW-1:0] haddr;
        logic              hwrite;
        logic [1:0]        htrans;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
        logic              hmastlock;
    } ctl_t;

    state_t              state, state_nxt;
    logic [MST_NUM-1:0]  grant, grant_nxt;
    logic [IW-1:0]       owner, owner_nxt;
    logic [IW-1:0]       ptr, ptr_nxt, ptr_adv, arb_base, arb_idx, cand;
    logic                arb_found;
    ctl_t                m_ctl [MST_NUM];
    logic [AHB_DW-1:0]   m_wdat [MST_NUM];
    ctl_t                own_ctl;
    logic [AHB_DW-1:0]   own_wdat;
    logic                own_cont;

    always_comb begin
        for (int i = 0; i < MST_NUM; i++) begin
            m_ctl[i].haddr     = m_haddr_i[i*AHB_AW +: AHB_AW];
            m_ctl[i].hwrite    = m_hwrite_i[i];
            m_ctl[i].htrans    = m_htrans_i[i*2 +: 2];
            m_ctl[i].hsize     = m_hsize_i[i*3 +: 3];
            m_ctl[i].hburst    = m_hburst_i[i*3 +: 3];
            m_ctl[i].hprot     = m_hprot_i[i*4 +: 4];
            m_ctl[i].hmastlock = m_hmastlock_i[i];
            m_wdat[i]          = m_hwdata_i[i*AHB_DW +: AHB_DW];
        end
    end

    assign own_ctl  = m_ctl[owner];
    assign own_wdat = m_wdat[owner];
    // Owner still mid-burst or holding a lock keeps the slave without re-arbitration.
    assign own_cont = own_ctl.hmastlock || (own_ctl.htrans == HTRANS_SEQ) ||
                      (own_ctl.htrans == HTRANS_BUSY);

    assign ptr_adv  = (owner == IW'(MST_NUM - 1)) ? '0 : owner + 1'b1;
    // On completion the search starts just past the owner so it only wins again when alone.
    assign arb_base = (state == ST_DATA) ? ptr_adv : ptr;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < MST_NUM; i++) begin
            cand = IW'((int'(arb_base) + i) % MST_NUM);
            if (!arb_found && m_req_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        case (state)
            ST_IDLE: begin
                if (arb_found) begin
                    state_nxt = ST_ADDR;
                    grant_nxt = GNT_ONE << arb_idx;
                    owner_nxt = arb_idx;
                end
            end
            ST_ADDR: state_nxt = ST_DATA;
            ST_DATA: begin
                if (hreadyout_i) begin
                    if (own_cont) begin
                        state_nxt = ST_ADDR;
                    end else begin
                        ptr_nxt = ptr_adv;
                        if (arb_found) begin
                            state_nxt = ST_ADDR;
                            grant_nxt = GNT_ONE << arb_idx;
                            owner_nxt = arb_idx;
                        end else begin
                            state_nxt = ST_IDLE;
                            grant_nxt = '0;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    assign m_grant_o = grant;

    always_comb begin
        hsel_o      = 1'b0;
        haddr_o     = '0;
        hwrite_o    = 1'b0;
        htrans_o    = HTRANS_IDLE;
        hsize_o     = '0;
        hburst_o    = '0;
        hprot_o     = '0;
        hmastlock_o = 1'b0;
        hwdata_o    = '0;
        hready_o    = 1'b1;
        s_hready_o  = 1'b1;
        s_hresp_o   = 1'b0;
        s_hrdata_o  = '0;
        case (state)
            ST_ADDR: begin
                hsel_o      = 1'b1;
                haddr_o     = own_ctl.haddr;
                hwrite_o    = own_ctl.hwrite;
                htrans_o    = own_ctl.htrans;
                hsize_o     = own_ctl.hsize;
                hburst_o    = own_ctl.hburst;
                hprot_o     = own_ctl.hprot;
                hmastlock_o = own_ctl.hmastlock;
                s_hready_o  = 1'b0;
            end
            ST_DATA: begin
                hwdata_o   = own_wdat;
                hready_o   = hreadyout_i;
                s_hready_o = hreadyout_i;
                s_hresp_o  = hresp_i;
                s_hrdata_o = hrdata_i;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ahblite_s_port.sv
// Directed bench for ahblite_s_port: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_ahblite_s_port;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  m_req, m_grant, m_hwrite, m_hmastlock;
    logic [N*AW-1:0] m_haddr;
    logic [N*2-1:0]  m_htrans;
    logic [N*3-1:0]  m_hsize, m_hburst;
    logic [N*4-1:0]  m_hprot;
    logic [N*DW-1:0] m_hwdata;
    logic          s_hready, s_hresp, hsel, hwrite, hmastlock, hready, hreadyout, hresp;
    logic [DW-1:0] s_hrdata, hwdata, hrdata;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic [2:0]    hsize, hburst;
    logic [3:0]    hprot;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ahblite_s_port #(.AHB_AW(AW), .AHB_DW(DW), .MST_NUM(N)) dut (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_grant_o(m_grant),
        .m_haddr_i(m_haddr), .m_hwrite_i(m_hwrite), .m_htrans_i(m_htrans),
        .m_hsize_i(m_hsize), .m_hburst_i(m_hburst), .m_hprot_i(m_hprot),
        .m_hmastlock_i(m_hmastlock), .m_hwdata_i(m_hwdata),
        .s_hready_o(s_hready), .s_hresp_o(s_hresp), .s_hrdata_o(s_hrdata),
        .hsel_o(hsel), .haddr_o(haddr), .hwrite_o(hwrite), .htrans_o(htrans),
        .hsize_o(hsize), .hburst_o(hburst), .hprot_o(hprot), .hmastlock_o(hmastlock),
        .hwdata_o(hwdata), .hready_o(hready),
        .hreadyout_i(hreadyout), .hresp_i(hresp), .hrdata_i(hrdata)
    );

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_req = '0; m_haddr = '0; m_hwrite = '0; m_htrans = '0; m_hsize = '0;
        m_hburst = '0; m_hprot = '0; m_hmastlock = '0; m_hwdata = '0;
        hreadyout = 1'b1; hresp = 1'b0; hrdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_mst(input int idx, input logic [AW-1:0] addr, input logic wr,
                           input logic [1:0] tr, input logic [DW-1:0] wd);
        m_haddr[idx*AW +: AW]  = addr;
        m_hwrite[idx]          = wr;
        m_htrans[idx*2 +: 2]   = tr;
        m_hsize[idx*3 +: 3]    = 3'b010;
        m_hburst[idx*3 +: 3]   = 3'b000;
        m_hprot[idx*4 +: 4]    = 4'b0011;
        m_hmastlock[idx]       = 1'b0;
        m_hwdata[idx*DW +: DW] = wd;
    endtask

    task automatic test_reset();
        do_reset();
        hresp = 1'b1;
        hrdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_cmp++; if (m_grant !== 4'b0000) begin n_err++; $display("FAIL rst_grant: got %b want 0000", m_grant); end
        n_cmp++; if (htrans !== 2'b00) begin n_err++; $display("FAIL rst_htrans: got %b want 00", htrans); end
        n_cmp++; if (hsel !== 1'b0) begin n_err++; $display("FAIL rst_hsel: got %b want 0", hsel); end
        n_cmp++; if (s_hready !== 1'b1) begin n_err++; $display("FAIL rst_s_hready: got %b want 1", s_hready); end
        n_cmp++; if (hready !== 1'b1) begin n_err++; $display("FAIL rst_hready: got %b want 1", hready); end
        n_cmp++; if (s_hresp !== 1'b0) begin n_err++; $display("FAIL rst_s_hresp: got %b want 0", s_hresp); end
        n_cmp++; if (s_hrdata !== 32'h0) begin n_err++; $display("FAIL rst_s_hrdata: got %h want 0", s_hrdata); end
        n_cmp++; if (haddr !== 32'h0) begin n_err++; $display("FAIL rst_haddr: got %h want 0", haddr); end
        n_cmp++; if (hwdata !== 32'h0) begin n_err++; $display("FAIL rst_hwdata: got %h want 0", hwdata); end
    endtask

    task automatic test_single_read();
        do_reset();
        set_mst(0, 32'h0001_0040, 1'b0, 2'b10, 32'h0);
        hrdata = 32'hDEAD_BEEF;
        m_req = 4'b0001;
        next_cyc();
        @(negedge clk);
        n_cmp++; if (m_grant !== 4'b0001) begin n_err++; $display("FAIL rd_grant: got %b want 0001", m_grant); end
        n_cmp++; if (haddr !== 32'h0001_0040) begin n_err++; $display("FAIL rd_haddr: got %h want 00010040", haddr); end
        n_cmp++; if (htrans !== 2'b10) begin n_err++; $display("FAIL rd_htrans: got %b want 10", htrans); end
        n_cmp++; if (hsel !== 1'b1) begin n_err++; $display("FAIL rd_hsel: got %b want 1", hsel); end
        n_cmp++; if (hsize !== 3'b010 || hprot !== 4'b0011) begin n_err++; $display("FAIL rd_ctl: got %b/%b want 010/0011", hsize, hprot); end
        n_cmp++; if (s_hready !== 1'b0) begin n_err++; $display("FAIL rd_addr_s_hready: got %b want 0", s_hready); end
        n_cmp++; if (s_hrdata !== 32'h0) begin n_err++; $display("FAIL rd_addr_s_hrdata: got %h want 0", s_hrdata); end
        next_cyc();
        m_req = 4'b0000;
        @(negedge clk);
        n_cmp++; if (s_hready !== 1'b1) begin n_err++; $display("FAIL rd_data_s_hready: got %b want 1", s_hready); end
        n_cmp++; if (s_hrdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data_s_hrdata: got %h want deadbeef", s_hrdata); end
        n_cmp++; if (htrans !== 2'b00) begin n_err++; $display("FAIL rd_data_htrans: got %b want 00", htrans); end
        next_cyc();
        @(negedge clk);
        n_cmp++; if (m_grant !== 4'b0000) begin n_err++; $display("FAIL rd_release: got %b want 0000", m_grant); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        do_reset();
        for (int i = 0; i < N; i++) set_mst(i, 32'h100 * (i + 1), 1'b0, 2'b10, 32'h0);
        m_req = 4'b1111;
        for (int c = 1; c <= 10; c++) begin
            next_cyc();
            @(negedge clk);
            n_cmp++;
            if (m_grant !== exp_g[(c-1)/2]) begin
                n_err++; $display("FAIL rr_grant c%0d: got %b want %b", c, m_grant, exp_g[(c-1)/2]);
            end
        end
    endtask

    task automatic test_burst();
        logic [3:0] exp_g;
        do_reset();
        set_mst(0, 32'h0000_0100, 1'b0, 2'b10, 32'h0);
        set_mst(2, 32'h0000_2000, 1'b0, 2'b10, 32'h0);
        m_hburst[8:6] = 3'b011;
        m_req = 4'b0100;
        for (int c = 1; c <= 9; c++) begin
            next_cyc();
            if (c == 2) m_req = 4'b0101;
            if (c >= 2 && c <= 7) m_htrans[5:4] = 2'b11;
            if (c == 8) begin m_htrans[5:4] = 2'b00; m_req = 4'b0001; end
            @(negedge clk);
            exp_g = (c <= 8) ? 4'b0100 : 4'b0001;
            n_cmp++;
            if (m_grant !== exp_g) begin n_err++; $display("FAIL burst_grant c%0d: got %b want %b", c, m_grant, exp_g); end
            if (c == 3) begin
                n_cmp++; if (htrans !== 2'b11 || hburst !== 3'b011) begin n_err++; $display("FAIL burst_seq: got %b/%b want 11/011", htrans, hburst); end
            end
            if (c == 9) begin
                n_cmp++; if (haddr !== 32'h0000_0100) begin n_err++; $display("FAIL burst_next_haddr: got %h want 00000100", haddr); end
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        set_mst(1, 32'h0000_1010, 1'b1, 2'b10, 32'hA5A5_0001);
        m_req = 4'b0010;
        next_cyc();
        @(negedge clk);
        n_cmp++; if (m_grant !== 4'b0010 || hwrite !== 1'b1) begin n_err++; $display("FAIL ws_addr: got %b/%b want 0010/1", m_grant, hwrite); end
        for (int c = 2; c <= 4; c++) begin
            next_cyc();
            hreadyout = 1'b0;
            @(negedge clk);
            n_cmp++; if (s_hready !== 1'b0) begin n_err++; $display("FAIL ws_s_hready c%0d: got %b want 0", c, s_hready); end
            n_cmp++; if (hready !== 1'b0) begin n_err++; $display("FAIL ws_hready c%0d: got %b want 0", c, hready); end
            n_cmp++; if (hwdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL ws_hwdata c%0d: got %h want a5a50001", c, hwdata); end
        end
        next_cyc();
        hreadyout = 1'b1;
        m_req = 4'b0000;
        @(negedge clk);
        n_cmp++; if (s_hready !== 1'b1 || hwdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL ws_done: got %b/%h want 1/a5a50001", s_hready, hwdata); end
        next_cyc();
        @(negedge clk);
        n_cmp++; if (m_grant !== 4'b0000 || hwdata !== 32'h0) begin n_err++; $display("FAIL ws_left: got %b/%h want 0000/0", m_grant, hwdata); end
    endtask

    task automatic test_error();
        do_reset();
        set_mst(3, 32'h0000_3000, 1'b0, 2'b10, 32'h0);
        m_req = 4'b1000;
        hresp = 1'b1;
        next_cyc();
        @(negedge clk);
        n_cmp++; if (s_hresp !== 1'b0) begin n_err++; $display("FAIL err_addr_hresp: got %b want 0", s_hresp); end
        next_cyc();
        hreadyout = 1'b0;
        @(negedge clk);
        n_cmp++; if (s_hresp !== 1'b1 || s_hready !== 1'b0) begin n_err++; $display("FAIL err_c1: got %b/%b want 1/0", s_hresp, s_hready); end
        next_cyc();
        hreadyout = 1'b1;
        m_htrans[7:6] = 2'b00;
        m_req = 4'b0000;
        @(negedge clk);
        n_cmp++; if (s_hresp !== 1'b1 || s_hready !== 1'b1) begin n_err++; $display("FAIL err_c2: got %b/%b want 1/1", s_hresp, s_hready); end
        next_cyc();
        hresp = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_grant !== 4'b0000 || s_hresp !== 1'b0) begin n_err++; $display("FAIL err_release: got %b/%b want 0000/0", m_grant, s_hresp); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_mst(2, 32'h0000_2200, 1'b0, 2'b10, 32'h0);
        m_req = 4'b0100;
        hreadyout = 1'b0;
        next_cyc();
        next_cyc();
        @(negedge clk);
        n_cmp++; if (m_grant !== 4'b0100 || s_hready !== 1'b0) begin n_err++; $display("FAIL arst_pre: got %b/%b want 0100/0", m_grant, s_hready); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (m_grant !== 4'b0000) begin n_err++; $display("FAIL arst_grant: got %b want 0000", m_grant); end
        n_cmp++; if (htrans !== 2'b00 || hsel !== 1'b0) begin n_err++; $display("FAIL arst_htrans: got %b/%b want 00/0", htrans, hsel); end
        n_cmp++; if (s_hready !== 1'b1) begin n_err++; $display("FAIL arst_s_hready: got %b want 1", s_hready); end
        m_req = 4'b0000;
        hreadyout = 1'b1;
        next_cyc();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_mst(0, 32'h0000_0100, 1'b0, 2'b10, 32'h0);
        set_mst(1, 32'h0000_0200, 1'b0, 2'b10, 32'h0);
        m_req = 4'b0001;
        next_cyc();
        next_cyc();
        m_req = 4'b0010;
        next_cyc();
        @(negedge clk);
        n_cmp++; if (m_grant !== 4'b0010) begin n_err++; $display("FAIL b2b_grant: got %b want 0010", m_grant); end
        n_cmp++; if (haddr !== 32'h0000_0200 || htrans !== 2'b10) begin n_err++; $display("FAIL b2b_addr: got %h/%b want 00000200/10", haddr, htrans); end
        next_cyc();
        next_cyc();
        @(negedge clk);
        n_cmp++; if (m_grant !== 4'b0010 || hsel !== 1'b1) begin n_err++; $display("FAIL b2b_regrant: got %b/%b want 0010/1", m_grant, hsel); end
        m_req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst();
        test_wait_states();
        test_error();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ahblite_s_port.md
Name: ahblite_s_port

Overview:
- Slave-side port of the AHB-Lite interconnect core. One instance per slave.
- Collects the request/grant handshake and the latched address/control/data from every master port, arbitrates round-robin, and drives a single AHB-Lite transfer stream into the attached slave.
- Returns the slave's hreadyout/hresp/hrdata on a broadcast bus. Each master port selects it with the grant this block issues.

Parameters:
AHB_AW, 32, address width
AHB_DW, 32, data width
MST_NUM, 4, number of master ports arbitrated (2..8)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
m_req_i  in  MST_NUM  per-master request (master port s_req_o)
m_grant_o  out  MST_NUM  one-hot registered grant to master ports
m_haddr_i  in  MST_NUM x AHB_AW  latched address per master
m_hwrite_i  in  MST_NUM  latched hwrite per master
m_htrans_i  in  MST_NUM x 2  latched htrans per master
m_hsize_i  in  MST_NUM x 3  latched hsize per master
m_hburst_i  in  MST_NUM x 3  latched hburst per master
m_hprot_i  in  MST_NUM x 4  latched hprot per master
m_hmastlock_i  in  MST_NUM  latched hmastlock per master
m_hwdata_i  in  MST_NUM x AHB_DW  latched hwdata per master
s_hready_o  out  1  hready returned to master ports
s_hresp_o  out  1  hresp returned to master ports
s_hrdata_o  out  AHB_DW  hrdata returned to master ports
hsel_o  out  1  slave select
haddr_o  out  AHB_AW  slave address
hwrite_o  out  1  slave hwrite
htrans_o  out  2  slave htrans
hsize_o  out  3  slave hsize
hburst_o  out  3  slave hburst
hprot_o  out  4  slave hprot
hmastlock_o  out  1  slave hmastlock
hwdata_o  out  AHB_DW  slave write data
hready_o  out  1  hready loop-back to slave
hreadyout_i  in  1  slave hreadyout
hresp_i  in  1  slave hresp
hrdata_i  in  AHB_DW  slave read data

Behaviour:
- Reset (async, rst=1):
  - FSM=IDLE, m_grant_o=0, round-robin pointer=0 (master 0 highest priority).
  - htrans_o=2'b00, hsel_o=0, s_hready_o=1, hready_o=1, s_hresp_o=0.
  - All other outputs 0.
  - Reset mid-transfer abandons the transfer immediately; no completion is signalled.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any m_req_i is set, the next grant goes to the first requester at or after the pointer, wrapping modulo MST_NUM.
  - Grant is registered, go to ADDR.
  - No requester: stay in IDLE.
- ADDR:
  - hsel_o=1, htrans_o=owner m_htrans_i, all control fields muxed from the owner.
  - s_hready_o=0, hready_o=1.
  - Go to DATA next cycle.
- DATA:
  - hwdata_o=owner m_hwdata_i, htrans_o=2'b00, hsel_o=0.
  - hready_o=hreadyout_i, s_hready_o=hreadyout_i, s_hresp_o=hresp_i, s_hrdata_o=hrdata_i.
  - While hreadyout_i=0: stay in DATA.
  - When hreadyout_i=1, choose the next state:
    - Owner m_htrans_i is SEQ (11) or BUSY (01), or owner m_hmastlock_i=1: keep grant, go to ADDR (burst/lock continuation, no re-arbitration).
    - Otherwise: advance pointer to owner+1, then re-arbitrate as in IDLE using the current m_req_i. Either go directly to ADDR with a new grant (the same master may win again only if no other master requests) or go to IDLE with m_grant_o=0.
- Outputs outside DATA: s_hresp_o=0 and s_hrdata_o=0.
- Error response: the two-cycle ERROR (hresp_i=1) is passed through unmodified. Release rules are unchanged.
- Grant timing:
  - m_grant_o changes only on a clock edge and is never multi-hot.
  - A request raised at cycle N in IDLE gives grant/ADDR at N+1 and DATA at N+2.
  - A zero-wait single transfer completes at N+2 (s_hready_o=1).
- Simultaneous events:
  - A request arriving the same cycle the owner completes is eligible in that cycle's arbitration.
  - A request deasserted while not granted is dropped without side effects.

Test Plan:
- Reset, then m_req_i=4'b0001 at cycle 1, addr 0x0001_0040, NONSEQ read, slave zero-wait, hrdata_i=0xDEADBEEF -> m_grant_o=0001 at cycle 2, haddr_o=0x0001_0040, htrans_o=10 at cycle 2; s_hready_o=1, s_hrdata_o=0xDEADBEEF at cycle 3; grant 0 at cycle 4.
- m_req_i=4'b1111 held continuously, single transfers, zero-wait -> grants in order 0001, 0010, 0100, 1000, 0001, each held exactly 2 cycles.
- Master 2 INCR4 burst (owner htrans SEQ after first beat) while master 0 requests -> master 2 keeps grant for 4 beats (8 cycles zero-wait); master 0 granted on the cycle after the final beat.
- Slave inserts 3 wait states (hreadyout_i=0 for 3 cycles in DATA) on a write of 0xA5A5_0001 -> s_hready_o=0 for 3 cycles, hwdata_o stable at 0xA5A5_0001 throughout, state leaves DATA on the 4th cycle.
- Slave ERROR response (hresp_i=1, hreadyout_i 0 then 1) -> s_hresp_o=1 both cycles, s_hready_o=0 then 1; grant released afterwards if owner htrans=IDLE.
- Assert rst asynchronously mid-DATA with m_grant_o=0100 -> m_grant_o=0, htrans_o=00, s_hready_o=1 immediately, without waiting for a clock edge.
